alsu_pipe: RTL and testbench

- Parametrised successor of the ALSU datapath: WIDTH-bit A/B operands, opcode-selected logic/arithmetic/shift, fixed two-stage pipeline with valid/ready flow control.
- Adds an invalid-operation flag and a divided LED blink engine that free-runs while the last retired op was invalid.
- Sits between the stimulus/ingress block and the result consumer; the UVM environment's scoreboard and assertions bind to its interface.

---
 rtl/alsu_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alsu_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alsu_pipe
//  Brief    : Two-stage pipelined ALSU (OR/XOR/ADD/MULT/SHIFT/ROTATE) with
//             valid/ready flow control, invalid-operation flag and an LED
//             blink engine that free-runs while the last retired op was
//             invalid.
//  Options  : define ALSU_SAT_EN to saturate ADD/MULT results at WIDTH bits.
//  Revision : 1.0  initial release
// ============================================================================
module alsu_pipe #(
  parameter int WIDTH          = 8,
  parameter     INPUT_PRIORITY = "A",
  parameter int LED_BLINK_DIV  = 4,
  parameter int LED_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               cin,
  input  logic               serial_in,
  input  logic               direction,
  input  logic               red_op_A,
  input  logic               red_op_B,
  input  logic               bypass_A,
  input  logic               bypass_B,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               err,
  output logic [LED_W-1:0]   leds
);

  // B wins a tie only when explicitly requested; anything else selects A.
  localparam bit c_prio_b = (INPUT_PRIORITY == "B");

  // Blink counter is at least one bit wide so a divide of 1 still works.
  localparam int c_cnt_w = (LED_BLINK_DIV > 1) ? $clog2(LED_BLINK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LED_BLINK_DIV - 1);

  localparam logic [2:0] c_op_or     = 3'd0;
  localparam logic [2:0] c_op_xor    = 3'd1;
  localparam logic [2:0] c_op_add    = 3'd2;
  localparam logic [2:0] c_op_mult   = 3'd3;
  localparam logic [2:0] c_op_shift  = 3'd4;
  localparam logic [2:0] c_op_rotate = 3'd5;

  // Everything stage 1 needs to remember about one operand set.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             serial_in;
    logic             direction;
    logic             red_a;
    logic             red_b;
    logic             byp_a;
    logic             byp_b;
    logic [2:0]       opcode;
  } op_t;

  typedef enum logic [0:0] {
    LED_IDLE  = 1'b0,
    LED_BLINK = 1'b1
  } led_state_t;

  // Pipeline state
  logic               s1_valid_q, s1_valid_d;
  op_t                s1_op_q, s1_op_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               err_q, err_d;

  // LED engine state
  led_state_t         led_state_q;
  logic [c_cnt_w-1:0] blink_cnt_q;
  logic [LED_W-1:0]   leds_q;

  // Combinational helpers
  op_t                w_in_op;
  logic               w_stall;
  logic               w_retire;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_add_ext;
  logic [2*WIDTH-1:0] w_mul_ext;
  logic [WIDTH-1:0]   w_red_sel;
  logic [WIDTH-1:0]   w_byp_sel;
  logic [WIDTH-1:0]   w_shift;
  logic [WIDTH-1:0]   w_rot;
  logic               w_invalid;
  logic [2*WIDTH-1:0] w_res;
  logic               w_err;

  // A stalled output register freezes the whole pipe.
  assign w_stall  = out_valid_q & ~out_ready;
  assign w_retire = out_valid_q & out_ready;
  assign in_ready = ~w_stall;

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;
  assign leds      = leds_q;

  // Gather the presented inputs into one operand record.
  always_comb begin
    w_in_op           = '0;
    w_in_op.a         = A;
    w_in_op.b         = B;
    w_in_op.cin       = cin;
    w_in_op.serial_in = serial_in;
    w_in_op.direction = direction;
    w_in_op.red_a     = red_op_A;
    w_in_op.red_b     = red_op_B;
    w_in_op.byp_a     = bypass_A;
    w_in_op.byp_b     = bypass_B;
    w_in_op.opcode    = opcode;
  end

  // Stage 1: capture the operand set whenever the pipe advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    if (!w_stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = w_in_op;
      end
    end
  end

  // Arithmetic and shift building blocks on the stage-1 operands.
  assign w_sum  = {1'b0, s1_op_q.a} + {1'b0, s1_op_q.b} + {{WIDTH{1'b0}}, s1_op_q.cin};
  assign w_prod = {{WIDTH{1'b0}}, s1_op_q.a} * {{WIDTH{1'b0}}, s1_op_q.b};

  assign w_shift = s1_op_q.direction ? {s1_op_q.a[WIDTH-2:0], s1_op_q.serial_in}
                                     : {s1_op_q.serial_in, s1_op_q.a[WIDTH-1:1]};
  assign w_rot   = s1_op_q.direction ? {s1_op_q.a[WIDTH-2:0], s1_op_q.a[WIDTH-1]}
                                     : {s1_op_q.a[0], s1_op_q.a[WIDTH-1:1]};

  assign w_red_sel = (s1_op_q.red_a & s1_op_q.red_b) ? (c_prio_b ? s1_op_q.b : s1_op_q.a)
                                                     : (s1_op_q.red_a ? s1_op_q.a : s1_op_q.b);
  assign w_byp_sel = (s1_op_q.byp_a & s1_op_q.byp_b) ? (c_prio_b ? s1_op_q.b : s1_op_q.a)
                                                     : (s1_op_q.byp_a ? s1_op_q.a : s1_op_q.b);

  // Reductions only make sense with OR/XOR; opcodes 6 and 7 are never legal.
  assign w_invalid = ((s1_op_q.red_a | s1_op_q.red_b) & (s1_op_q.opcode > c_op_xor))
                   | (s1_op_q.opcode > c_op_rotate);

`ifdef ALSU_SAT_EN
  // Clamp ADD/MULT to the largest WIDTH-bit value on overflow.
  assign w_add_ext = w_sum[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                  : {{(WIDTH-1){1'b0}}, w_sum};
  assign w_mul_ext = (|w_prod[2*WIDTH-1:WIDTH]) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                                : w_prod;
`else
  assign w_add_ext = {{(WIDTH-1){1'b0}}, w_sum};
  assign w_mul_ext = w_prod;
`endif

  // Result select: bypass first, then the invalid check, then the opcode.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    if (s1_op_q.byp_a | s1_op_q.byp_b) begin
      w_res = {{WIDTH{1'b0}}, w_byp_sel};
    end else if (w_invalid) begin
      w_err = 1'b1;
    end else begin
      case (s1_op_q.opcode)
        c_op_or: begin
          if (s1_op_q.red_a | s1_op_q.red_b) w_res = {{(2*WIDTH-1){1'b0}}, |w_red_sel};
          else                               w_res = {{WIDTH{1'b0}}, s1_op_q.a | s1_op_q.b};
        end
        c_op_xor: begin
          if (s1_op_q.red_a | s1_op_q.red_b) w_res = {{(2*WIDTH-1){1'b0}}, ^w_red_sel};
          else                               w_res = {{WIDTH{1'b0}}, s1_op_q.a ^ s1_op_q.b};
        end
        c_op_add:    w_res = w_add_ext;
        c_op_mult:   w_res = w_mul_ext;
        c_op_shift:  w_res = {{WIDTH{1'b0}}, w_shift};
        c_op_rotate: w_res = {{WIDTH{1'b0}}, w_rot};
        default:     w_res = '0;
      endcase
    end
  end

  // Stage 2: register the computed result; bubbles leave a zeroed output.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_d       = err_q;
    if (!w_stall) begin
      out_valid_d = s1_valid_q;
      out_d       = s1_valid_q ? w_res : '0;
      err_d       = s1_valid_q & w_err;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  // LED engine: retires steer the state, the divider toggles leds in BLINK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_state_q <= LED_IDLE;
      blink_cnt_q <= '0;
      leds_q      <= '0;
    end else begin
      case (led_state_q)
        LED_IDLE: begin
          if (w_retire && err_q) begin
            led_state_q <= LED_BLINK;
            blink_cnt_q <= '0;
            leds_q      <= '1;
          end
        end
        LED_BLINK: begin
          if (w_retire) begin
            // A retire overrides a coincident divider wrap.
            blink_cnt_q <= '0;
            if (!err_q) begin
              led_state_q <= LED_IDLE;
              leds_q      <= '0;
            end
          end else if (blink_cnt_q == c_cnt_last) begin
            blink_cnt_q <= '0;
            leds_q      <= ~leds_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + c_cnt_w'(1);
          end
        end
        default: begin
          led_state_q <= LED_IDLE;
          blink_cnt_q <= '0;
          leds_q      <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alsu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alsu_pipe
//  Brief    : Self-checking bench for alsu_pipe: directed literal cases plus
//             randomized traffic compared every cycle to a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alsu_pipe;

  localparam int W      = 8;
  localparam int DIV    = 4;
  localparam int LW     = 16;
  localparam bit PRIO_B = 1'b1;

`ifdef ALSU_SAT_EN
  localparam logic [2*W-1:0] EXP_ADD  = 16'h00FF;
  localparam logic [2*W-1:0] EXP_MULT = 16'h00FF;
`else
  localparam logic [2*W-1:0] EXP_ADD  = 16'h0100;
  localparam logic [2*W-1:0] EXP_MULT = 16'hFE01;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           cin = 1'b0;
  logic           serial_in = 1'b0;
  logic           direction = 1'b0;
  logic           red_op_A = 1'b0;
  logic           red_op_B = 1'b0;
  logic           bypass_A = 1'b0;
  logic           bypass_B = 1'b0;
  logic [2:0]     opcode = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out;
  logic           err;
  logic [LW-1:0]  leds;

  always #5 clk = ~clk;

  alsu_pipe #(
    .WIDTH(W), .INPUT_PRIORITY("B"), .LED_BLINK_DIV(DIV), .LED_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
    .bypass_B(bypass_B), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .err(err), .leds(leds)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one operation, from the operation definitions.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic si, input logic dir,
                        input logic ra, input logic rb, input logic ba, input logic bb,
                        input logic [2:0] op,
                        output logic [2*W-1:0] res, output logic e);
    longint ua, ub, r, top, sel;
    ua  = longint'(a);
    ub  = longint'(b);
    top = longint'(1) << W;
    r   = 0;
    e   = 1'b0;
    if (ba || bb) begin
      r = (ba && bb) ? (PRIO_B ? ub : ua) : (ba ? ua : ub);
    end else if (op >= 3'd6 || ((ra || rb) && op >= 3'd2)) begin
      e = 1'b1;
    end else begin
      sel = (ra && rb) ? (PRIO_B ? ub : ua) : (ra ? ua : ub);
      case (op)
        3'd0:    r = (ra || rb) ? ((sel != 0) ? 1 : 0) : (ua | ub);
        3'd1:    r = (ra || rb) ? longint'($countones(sel) % 2) : (ua ^ ub);
        3'd2:    r = ua + ub + longint'(c);
        3'd3:    r = ua * ub;
        3'd4:    r = dir ? ((ua * 2) % top + longint'(si)) : (ua / 2 + longint'(si) * (top / 2));
        3'd5:    r = dir ? ((ua * 2) % top + ua / (top / 2)) : (ua / 2 + (ua % 2) * (top / 2));
        default: r = 0;
      endcase
`ifdef ALSU_SAT_EN
      if ((op == 3'd2 || op == 3'd3) && r > top - 1) r = top - 1;
`endif
    end
    res = r[2*W-1:0];
  endtask

  // Model: two pipeline slots that advance unless the output is held,
  // plus the LED pattern as a function of edges since the last invalid retire.
  logic           m_s1v = 1'b0, m_ov = 1'b0, m_s1err = 1'b0, m_err = 1'b0;
  logic [2*W-1:0] m_s1res = '0, m_out = '0;
  logic           m_blink = 1'b0;
  logic [LW-1:0]  m_base = '0;
  longint         m_n = 0, m_base_n = 0;

  function automatic logic [LW-1:0] led_exp(input longint n);
    if (!m_blink) return '0;
    if (((n - m_base_n) / DIV) % 2 == 1) return ~m_base;
    return m_base;
  endfunction

  task automatic m_reset();
    m_s1v = 1'b0; m_ov = 1'b0; m_s1err = 1'b0; m_err = 1'b0;
    m_s1res = '0; m_out = '0; m_blink = 1'b0; m_base = '0;
  endtask

  task automatic model_step();
    logic retire, stall, e;
    logic [LW-1:0]  cur;
    logic [2*W-1:0] r;
    retire = m_ov && out_ready;
    stall  = m_ov && !out_ready;
    cur    = led_exp(m_n);
    m_n++;
    if (retire) begin
      if (m_err) begin
        m_base   = m_blink ? cur : '1;
        m_blink  = 1'b1;
        m_base_n = m_n;
      end else begin
        m_blink = 1'b0;
      end
    end
    if (!stall) begin
      m_ov  = m_s1v;
      m_out = m_s1v ? m_s1res : '0;
      m_err = m_s1v && m_s1err;
      ref_op(A, B, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B, opcode, r, e);
      m_s1v   = in_valid;
      m_s1res = r;
      m_s1err = e;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_err", err, 0);
      chk("rst_leds", leds, 0);
    end else begin
      chk("out_valid", out_valid, m_ov);
      chk("in_ready", in_ready, !(m_ov && !out_ready));
      if (m_ov) begin
        chk("out", out, m_out);
        chk("err", err, m_err);
      end
      chk("leds", leds, led_exp(m_n));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic c, input logic si, input logic dir,
                        input logic ra, input logic rb, input logic ba, input logic bb);
    A = a; B = b; opcode = op; cin = c; serial_in = si; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb; in_valid = 1'b1;
  endtask

  // Issue one op into an empty pipe and check it two cycles after acceptance.
  task automatic issue_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op, input logic c, input logic ba, input logic bb,
                             input logic [2*W-1:0] exp, input logic exp_err);
    step();
    set_op(a, b, op, c, 1'b0, 1'b0, 1'b0, 1'b0, ba, bb);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_out"}, out, exp);
    chk({name, "_err"}, err, exp_err);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_leds", leds, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);

    // Directed literal cases
    issue_check("add", 8'hF0, 8'h0F, 3'd2, 1'b1, 1'b0, 1'b0, EXP_ADD, 1'b0);
    issue_check("mult", 8'hFF, 8'hFF, 3'd3, 1'b0, 1'b0, 1'b0, EXP_MULT, 1'b0);
    issue_check("bypass_both", 8'h12, 8'h34, 3'd7, 1'b0, 1'b1, 1'b1, 16'h0034, 1'b0);
    issue_check("invalid", 8'hAB, 8'hCD, 3'd6, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    chk("blink_on", leds, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("blink_hold", leds, 16'hFFFF);
    @(negedge clk);
    chk("blink_toggle", leds, 16'h0000);
    repeat (4) @(negedge clk);
    chk("blink_toggle2", leds, 16'hFFFF);
    issue_check("or_after_blink", 8'h0C, 8'h30, 3'd0, 1'b0, 1'b0, 1'b0, 16'h003C, 1'b0);
    @(negedge clk);
    chk("blink_exit", leds, 16'h0000);

    // Stall with two ops in flight
    step();
    out_ready = 1'b0;
    set_op(8'h5A, 8'h81, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(8'h5A, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out", out, 16'h00DB);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_first", out, 16'h00DB);
    @(negedge clk);
    chk("drain_second", out, 16'h00A5);
    chk("drain_second_valid", out_valid, 1);
    @(negedge clk);
    chk("drain_done", out_valid, 0);

    // Reset with two ops in flight while blinking
    step();
    set_op(8'h00, 8'h00, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_leds", leds, 16'hFFFF);
    set_op(8'hF0, 8'h0F, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(8'hFF, 8'hFF, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_leds", leds, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       A = '0;
        1:       A = '1;
        default: A = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       B = '0;
        1:       B = '1;
        default: B = W'($urandom);
      endcase
      opcode    = 3'($urandom_range(0, 7));
      cin       = 1'($urandom);
      serial_in = 1'($urandom);
      direction = 1'($urandom);
      red_op_A  = ($urandom_range(0, 7) == 0);
      red_op_B  = ($urandom_range(0, 7) == 0);
      bypass_A  = ($urandom_range(0, 11) == 0);
      bypass_B  = ($urandom_range(0, 11) == 0);
      if (cyc % 997 == 500) begin
        #2;
        rst = 1'b0;
        m_reset();
        step();
        rst = 1'b1;
      end
    end

    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
